// File: rtl/convclk_grayffpf.sv
// convclk_grayffpf: read-side prefetch buffer for the gray-pointer clock-crossing FIFO.
// Ports: rdclk/rdrst (sync active-high), fiford pop request, read accepted pop,
// fifoflush shared flush, ramdata RAM return (RDLAT after read), dout/dvalid/dready
// output stream, bufcnt local occupancy, perr parity error pulse.
// Optional feature: define CONVCLK_GRAYFFPF_PAR_EN for even parity on ramdata[DATW].
module convclk_grayffpf #(
  parameter int DATW  = 8,
  parameter int RDLAT = 1
) (
  input  logic            rdclk,
  input  logic            rdrst,
  output logic            fiford,
  input  logic            read,
  input  logic            fifoflush,
`ifdef CONVCLK_GRAYFFPF_PAR_EN
  input  logic [DATW:0]   ramdata,
`else
  input  logic [DATW-1:0] ramdata,
`endif
  output logic [DATW-1:0] dout,
  output logic            dvalid,
  input  logic            dready,
  output logic [1:0]      bufcnt,
  output logic            perr
);
  localparam int DEPTH = RDLAT + 1;
  localparam int PW = $clog2(DEPTH);
  logic [RDLAT-1:0] trk;
  logic [DATW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [2:0] occ;
  logic cap, pop, par_bad;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
`ifdef CONVCLK_GRAYFFPF_PAR_EN
  assign par_bad = ^ramdata;
`else
  assign par_bad = 1'b0;
`endif
  assign dvalid = bufcnt != 2'd0;
  assign dout = mem[rp];
  // In-flight words plus buffered words never exceed DEPTH, so every capture finds a free slot;
  // a pop in this cycle frees a slot early, which keeps one word per cycle under dready=1.
  always_comb begin
    cap = trk[RDLAT-1];
    pop = dvalid & dready;
    occ = 3'($countones(trk)) + 3'(bufcnt);
    fiford = ~fifoflush & ~rdrst & ((occ < 3'(DEPTH)) | pop);
  end
  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      trk <= '0;
      wp <= '0;
      rp <= '0;
      bufcnt <= '0;
      perr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fifoflush) begin
      trk <= '0;
      wp <= '0;
      rp <= '0;
      bufcnt <= '0;
      perr <= 1'b0;
    end else begin
      trk <= RDLAT'({trk, read});
      if (cap) begin
        mem[wp] <= ramdata[DATW-1:0];
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      bufcnt <= bufcnt + 2'(cap) - 2'(pop);
      perr <= cap & par_bad;
    end
  end
endmodule

// File: tb/tb_convclk_grayffpf.sv
// tb_convclk_grayffpf: randomized check of the prefetch buffer (RDLAT 1 and 2) against a word-queue model.
module tb_convclk_grayffpf;
`ifdef CONVCLK_GRAYFFPF_PAR_EN
  localparam int RW = 9;
`else
  localparam int RW = 8;
`endif
  typedef struct {logic [7:0] d; int t; bit bad;} ent_t;
  logic rdclk = 1'b0, rdrst = 1'b1, fifoflush = 1'b0, dready = 1'b0;
  logic fiford [2], read [2], dvalid [2], perr [2];
  logic [RW-1:0] ramdata [2];
  logic [7:0] dout [2];
  logic [1:0] bufcnt [2];
  ent_t exq [2][$];
  logic [7:0] up [2][$];
  logic [RW-1:0] rsch [2][8];
  int checks = 0, errors = 0, cyc = 0;
  int nreads [2] = '{0, 0};
  bit inj = 0;
  always #5 rdclk = ~rdclk;
  convclk_grayffpf #(.DATW(8), .RDLAT(1)) u0 (.rdclk(rdclk), .rdrst(rdrst), .fiford(fiford[0]), .read(read[0]),
    .fifoflush(fifoflush), .ramdata(ramdata[0]), .dout(dout[0]), .dvalid(dvalid[0]), .dready(dready),
    .bufcnt(bufcnt[0]), .perr(perr[0]));
  convclk_grayffpf #(.DATW(8), .RDLAT(2)) u1 (.rdclk(rdclk), .rdrst(rdrst), .fiford(fiford[1]), .read(read[1]),
    .fifoflush(fifoflush), .ramdata(ramdata[1]), .dout(dout[1]), .dvalid(dvalid[1]), .dready(dready),
    .bufcnt(bufcnt[1]), .perr(perr[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [RW-1:0] enc(input logic [7:0] w, input bit bad);
    logic [8:0] x;
    x = {^w ^ bad, w};
    return x[RW-1:0];
  endfunction
  // One read-clock cycle: drive inputs, compare against the word-queue model, react as the controller, advance.
  task automatic step(input logic rdy, input logic fl, input logic rs);
    int nb;
    logic dv, pe, fe;
    logic [7:0] w;
    bit bad;
    rdrst = rs;
    fifoflush = fl;
    dready = rdy;
    for (int l = 0; l < 2; l++) begin
      ramdata[l] = rsch[l][cyc % 8];
      rsch[l][cyc % 8] = RW'($urandom);
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      nb = 0;
      pe = 0;
      for (int i = 0; i < exq[l].size(); i++) begin
        if (exq[l][i].t <= cyc) nb++;
        if (exq[l][i].t == cyc && exq[l][i].bad) pe = 1;
      end
      dv = exq[l].size() > 0 && exq[l][0].t <= cyc;
      fe = !fl && !rs && (exq[l].size() < l + 2 || (dv && rdy));
      chk($sformatf("L%0d fiford", l), 32'(fiford[l]), 32'(fe));
      chk($sformatf("L%0d dvalid", l), 32'(dvalid[l]), 32'(dv));
      chk($sformatf("L%0d bufcnt", l), 32'(bufcnt[l]), 32'(nb));
      chk($sformatf("L%0d perr", l), 32'(perr[l]), 32'(pe));
      if (dv) chk($sformatf("L%0d dout", l), 32'(dout[l]), 32'(exq[l][0].d));
      read[l] = fiford[l] && up[l].size() > 0;
      if (!rs && !fl && dv && rdy) void'(exq[l].pop_front());
      if (read[l]) begin
        w = up[l].pop_front();
        bad = RW == 9 && inj && w == 8'hA5;
        exq[l].push_back('{d: w, t: cyc + l + 2, bad: bad});
        rsch[l][(cyc + l + 1) % 8] = enc(w, bad);
        nreads[l]++;
      end
      if (fl || rs) exq[l].delete();
    end
    @(posedge rdclk);
    #1;
    cyc++;
  endtask
  task automatic load(input logic [7:0] w);
    up[0].push_back(w);
    up[1].push_back(w);
  endtask
  task automatic drain(input int maxc, input bit rnd);
    int n = 0;
    while ((up[0].size() + up[1].size() + exq[0].size() + exq[1].size()) > 0 && n < maxc) begin
      step(rnd ? logic'($urandom_range(2) != 0) : 1'b1, rnd ? logic'($urandom_range(49) == 0) : 1'b0,
           rnd && n == 300);
      n++;
    end
    chk("drain_done", 32'(n < maxc), 32'd1);
  endtask
  initial begin
    int b0, b1;
    for (int l = 0; l < 2; l++) begin
      read[l] = 1'b0;
      ramdata[l] = '0;
      for (int i = 0; i < 8; i++) rsch[l][i] = '0;
    end
    repeat (2) @(posedge rdclk);
    #1;
    for (int l = 0; l < 2; l++) chk($sformatf("L%0d rst_dout", l), 32'(dout[l]), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    load(8'h11);
    load(8'h22);
    load(8'h33);
    drain(50, 1'b0);
    b0 = nreads[0];
    b1 = nreads[1];
    repeat (5) load(8'($urandom));
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("L1 bp_reads", 32'(nreads[1] - b1), 32'd3);
    chk("L0 bp_reads", 32'(nreads[0] - b0), 32'd2);
    chk("L1 bp_bufcnt", 32'(bufcnt[1]), 32'd3);
    chk("L1 bp_fiford", 32'(fiford[1]), 32'd0);
    drain(50, 1'b0);
    repeat (100) load(8'($urandom));
    drain(200, 1'b0);
    repeat (6) load(8'($urandom));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain(50, 1'b0);
    repeat (1000) load(8'($urandom));
    drain(8000, 1'b1);
    inj = 1;
    load(8'h3C);
    load(8'hA5);
    load(8'h5A);
    load(8'hA5);
    drain(50, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
